hybrid_core: RTL and testbench
==============================

HYBRID_CORE -- requirements
Module: hybrid_core

Interface
REQ-001 The module SHALL have one parameter: DW, default 12, sample width in bits (sign-magnitude).
REQ-002 The module SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port t_select, input, 2 bits: transform select (00 bypass, 01 8-point DFT, 10 8-point Walsh-Hadamard, 11 reserved).
REQ-005 The module SHALL have ports I0..I7, input, DW bits each: real input samples x[0..7]; bit DW-1 is the sign (1 = negative), bits DW-2:0 are the magnitude.
REQ-006 The module SHALL have ports rO0..rO7, output, DW bits each: real part of result k, in sign-magnitude.
REQ-007 The module SHALL have ports iO0..iO7, output, DW bits each: imaginary part of result k, in sign-magnitude.

Function
REQ-008 On each rising CLK edge with RESET low, the module SHALL register outputs computed combinationally from the current I0..I7 and t_select (latency 1 cycle).
REQ-009 Inputs SHALL be converted to two's complement before arithmetic; -0 (sign 1, magnitude 0) SHALL equal 0.
REQ-010 Internal arithmetic SHALL be signed with DW+4 bits; no intermediate saturation.
REQ-011 t_select=00 or 11: rOk = Ik re-encoded (a -0 input becomes +0); iOk = 0.
REQ-012 t_select=01: X[k] = sum over n of x[n]·W8^(nk), with W8 = e^(-j2π/8), unscaled.
REQ-013 The DFT SHALL be implemented as a 3-stage radix-2 decimation-in-time butterfly network: bit-reversed input, natural-order output.
REQ-014 Multiplication by ±1 or ±j SHALL be exact (swap/negate).
REQ-015 Multiplication by (±1±j)/√2 SHALL be done per component: multiply by constant 181, add 128, arithmetic shift right 8.
REQ-016 t_select=10: Y[k] = sum over n of x[n]·(-1)^popcount(k AND n) (Sylvester/natural order, unscaled); all iOk = 0.
REQ-017 Final output conversion: values beyond ±(2^(DW-1)-1) SHALL saturate to magnitude 2^(DW-1)-1; sign bit = 1 only for strictly negative values; zero is always +0.
REQ-018 A t_select change SHALL take effect on the next rising edge; there is no mode-transition state or flush.
REQ-019 X/Z on inputs before the first valid sample is not a requirement; outputs are only defined for defined inputs.

Reset
REQ-020 While RESET is high at a rising edge, all rO0..rO7 and iO0..iO7 SHALL become 0, overriding any computation.
REQ-021 The first computed result SHALL appear at the first rising edge with RESET low.
REQ-022 RESET asserted mid-stream SHALL clear outputs at that edge; operation resumes on the next edge with no residual state.

Structure
REQ-023 A shared package SHALL hold the t_select encodings (SEL_BYP=00, SEL_DFT=01, SEL_WHT=10), DW default, the internal width offset (4), and the twiddle constants (181, rounding 128, shift 8).
REQ-024 One sub-module, hybrid_butterfly, SHALL be used: a complex radix-2 butterfly producing a+b and a-b on (re, im) pairs in DW+4-bit signed arithmetic.
REQ-025 Sign-magnitude/two's-complement conversion and saturation SHALL be functions in the package.

Verification
Input x = [-3, -7, 15, 2, 8, -4, -11, 1] for every scenario below (I0=12'h803, I1=12'h807, I2=12'h00F, I3=12'h002, I4=12'h008, I5=12'h804, I6=12'h80B, I7=12'h001).
REQ-026 RESET high for 1 edge -> all 16 outputs 12'h000.
REQ-027 t_select=01 with x -> after 1 edge: rO0=12'h001, iO0=0; rO4=12'h011 (17), iO4=0; rO2=12'h001, iO2=12'h00E (14); rO6=12'h001, iO6=12'h80E (-14).
REQ-028 t_select=10 with x -> rO0=12'h001, rO1=12'h011 (17), rO4=12'h00D (13); all iOk=0.
REQ-029 t_select=00 with x -> rOk = Ik for all k; all iOk=0. Then switch to 01 -> DFT values appear on the next edge.
REQ-030 Saturation/zero: t_select=01 with all Ik=12'h7FF -> rO0=12'h7FF; rO1..rO7=0; all iOk=0. Repeat with I0=12'h800 (-0) and t_select=00 -> rO0=12'h000.
REQ-031 Reset mid-stream: assert RESET during DFT operation -> outputs 0 at that edge; deassert -> correct DFT result one edge later.

Source files
------------

// File: rtl/hybrid_core_pkg.sv
// rtl/hybrid_core_pkg.sv - shared encodings, widths, twiddle constants and number-format helpers
package hybrid_core_pkg;

  typedef enum logic [1:0] {
    SEL_BYP = 2'b00,
    SEL_DFT = 2'b01,
    SEL_WHT = 2'b10,
    SEL_RSV = 2'b11
  } sel_e;

  localparam int DW_DEF = 12;
  localparam int W_OFF  = 4;
  localparam int TW_MUL = 181;
  localparam int TW_RND = 128;
  localparam int TW_SH  = 8;

  // Sign-magnitude of width dw to two's complement; -0 maps to 0.
  function automatic int sm_to_tc(input logic [31:0] v, input int dw);
    int mag;
    mag = int'(v & ((32'd1 << (dw - 1)) - 32'd1));
    return v[dw-1] ? -mag : mag;
  endfunction

  // Two's complement to sign-magnitude of width dw, saturating to +/-(2^(dw-1)-1).
  function automatic logic [31:0] tc_to_sm(input int v, input int dw);
    int          maxv;
    logic [31:0] sgn;
    maxv = (1 << (dw - 1)) - 1;
    sgn  = 32'd1 << (dw - 1);
    if (v > maxv) return 32'(maxv);
    if (v < -maxv) return sgn | 32'(maxv);
    if (v < 0) return sgn | 32'(-v);
    return 32'(v);
  endfunction

  function automatic int tw_rnd(input int v);
    return (v * TW_MUL + TW_RND) >>> TW_SH;
  endfunction

  // Multiply (re + j*im) by W8^k, k = 0..3; result packed as {re, im}.
  function automatic logic [63:0] tw_mul(input int re, input int im, input logic [1:0] k);
    case (k)
      2'd0:    return {re, im};
      2'd1:    return {tw_rnd(re + im), tw_rnd(im - re)};
      2'd2:    return {im, -re};
      default: return {tw_rnd(im - re), tw_rnd(-re - im)};
    endcase
  endfunction

endpackage

// File: rtl/hybrid_butterfly.sv
// rtl/hybrid_butterfly.sv - complex radix-2 butterfly: s = a + b, d = a - b
module hybrid_butterfly #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a_re,
  input  logic signed [W-1:0] a_im,
  input  logic signed [W-1:0] b_re,
  input  logic signed [W-1:0] b_im,
  output logic signed [W-1:0] s_re,
  output logic signed [W-1:0] s_im,
  output logic signed [W-1:0] d_re,
  output logic signed [W-1:0] d_im
);

  assign s_re = a_re + b_re;
  assign s_im = a_im + b_im;
  assign d_re = a_re - b_re;
  assign d_im = a_im - b_im;

endmodule

// File: rtl/hybrid_core.sv
// rtl/hybrid_core.sv - registered 8-point bypass / DFT / Walsh-Hadamard on sign-magnitude samples
module hybrid_core
  import hybrid_core_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [1:0]    t_select,
  input  logic [DW-1:0] I0, I1, I2, I3, I4, I5, I6, I7,
  output logic [DW-1:0] rO0, rO1, rO2, rO3, rO4, rO5, rO6, rO7,
  output logic [DW-1:0] iO0, iO1, iO2, iO3, iO4, iO5, iO6, iO7
);

  localparam int IW = DW + W_OFF;

  logic [DW-1:0]        in_sm [8];
  logic signed [IW-1:0] x     [8];
  logic signed [IW-1:0] sr    [4][8];
  logic signed [IW-1:0] si    [4][8];
  logic signed [IW-1:0] wht   [8];
  logic [DW-1:0]        nr    [8];
  logic [DW-1:0]        ni    [8];
  logic [DW-1:0]        ro_q  [8];
  logic [DW-1:0]        io_q  [8];

  assign in_sm = '{I0, I1, I2, I3, I4, I5, I6, I7};

  always_comb begin
    for (int k = 0; k < 8; k++) x[k] = IW'(sm_to_tc(32'(in_sm[k]), DW));
  end

  // Stage 0 holds the samples in bit-reversed order; stages 1..3 are butterfly outputs.
  for (genvar n = 0; n < 8; n++) begin : g_brev
    localparam logic [2:0] N3 = 3'(n);
    assign sr[0][n] = x[{N3[0], N3[1], N3[2]}];
    assign si[0][n] = '0;
  end

  for (genvar s = 0; s < 3; s++) begin : g_stage
    for (genvar p = 0; p < 4; p++) begin : g_bf
      localparam int         H  = 1 << s;
      localparam int         IA = (p / H) * 2 * H + (p % H);
      localparam int         IB = IA + H;
      localparam logic [1:0] TW = 2'((p % H) * (4 >> s));

      logic [63:0]          twp;
      logic signed [IW-1:0] b_re, b_im;

      assign twp  = tw_mul(int'(sr[s][IB]), int'(si[s][IB]), TW);
      assign b_re = IW'($signed(twp[63:32]));
      assign b_im = IW'($signed(twp[31:0]));

      hybrid_butterfly #(.W(IW)) u_bf (
        .a_re (sr[s][IA]),
        .a_im (si[s][IA]),
        .b_re (b_re),
        .b_im (b_im),
        .s_re (sr[s+1][IA]),
        .s_im (si[s+1][IA]),
        .d_re (sr[s+1][IB]),
        .d_im (si[s+1][IB])
      );
    end
  end

  // Walsh-Hadamard sign is the parity of k AND n.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      wht[k] = '0;
      for (int n = 0; n < 8; n++) begin
        if (^(3'(k) & 3'(n))) wht[k] = wht[k] - x[n];
        else                  wht[k] = wht[k] + x[n];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      nr[k] = DW'(tc_to_sm(int'(x[k]), DW));
      ni[k] = '0;
      case (sel_e'(t_select))
        SEL_DFT: begin
          nr[k] = DW'(tc_to_sm(int'(sr[3][k]), DW));
          ni[k] = DW'(tc_to_sm(int'(si[3][k]), DW));
        end
        SEL_WHT: nr[k] = DW'(tc_to_sm(int'(wht[k]), DW));
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ro_q <= '{default: '0};
      io_q <= '{default: '0};
    end else begin
      ro_q <= nr;
      io_q <= ni;
    end
  end

  assign {rO0, rO1, rO2, rO3, rO4, rO5, rO6, rO7} =
         {ro_q[0], ro_q[1], ro_q[2], ro_q[3], ro_q[4], ro_q[5], ro_q[6], ro_q[7]};
  assign {iO0, iO1, iO2, iO3, iO4, iO5, iO6, iO7} =
         {io_q[0], io_q[1], io_q[2], io_q[3], io_q[4], io_q[5], io_q[6], io_q[7]};

endmodule

// File: tb/tb_hybrid_core.sv
// tb/tb_hybrid_core.sv - scoreboard bench for hybrid_core with an independent transform model
module tb_hybrid_core;

  typedef struct packed {
    logic [7:0][11:0] r;
    logic [7:0][11:0] i;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [1:0]       t_select = 2'b00;
  logic [7:0][11:0] xin = '0;
  logic [7:0][11:0] obs_r, obs_i;
  logic [7:0][11:0] xs, xsat;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  hybrid_core #(.DW(12)) dut (
    .CLK(clk), .RESET(reset), .t_select(t_select),
    .I0(xin[0]), .I1(xin[1]), .I2(xin[2]), .I3(xin[3]),
    .I4(xin[4]), .I5(xin[5]), .I6(xin[6]), .I7(xin[7]),
    .rO0(obs_r[0]), .rO1(obs_r[1]), .rO2(obs_r[2]), .rO3(obs_r[3]),
    .rO4(obs_r[4]), .rO5(obs_r[5]), .rO6(obs_r[6]), .rO7(obs_r[7]),
    .iO0(obs_i[0]), .iO1(obs_i[1]), .iO2(obs_i[2]), .iO3(obs_i[3]),
    .iO4(obs_i[4]), .iO5(obs_i[5]), .iO6(obs_i[6]), .iO7(obs_i[7])
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic int sm2i(input logic [11:0] v);
    int m;
    m = int'(v[10:0]);
    return v[11] ? -m : m;
  endfunction

  function automatic logic [11:0] i2sm(input int v);
    if (v > 2047) return 12'h7FF;
    if (v < -2047) return 12'hFFF;
    if (v < 0) return {1'b1, 11'(-v)};
    return {1'b0, 11'(v)};
  endfunction

  function automatic int rnd181(input int v);
    return (v * 181 + 128) >>> 8;
  endfunction

  function automatic exp_t model(input logic rst, input logic [1:0] sel, input logic [7:0][11:0] xv);
    exp_t e;
    int   x[8];
    int   er, ei, odr, odi, tr, ti, cr, ci, pm, acc;
    e = '0;
    if (rst) return e;
    for (int n = 0; n < 8; n++) x[n] = sm2i(xv[n]);
    if (sel == 2'b01) begin
      for (int kk = 0; kk < 4; kk++) begin
        er = 0; ei = 0; odr = 0; odi = 0;
        for (int m = 0; m < 4; m++) begin
          pm = (m * kk) % 4;
          case (pm)
            0: begin er += x[2*m];  odr += x[2*m+1]; end
            1: begin ei -= x[2*m];  odi -= x[2*m+1]; end
            2: begin er -= x[2*m];  odr -= x[2*m+1]; end
            default: begin ei += x[2*m]; odi += x[2*m+1]; end
          endcase
        end
        case (kk)
          0: begin tr = odr; ti = odi; end
          2: begin tr = odi; ti = -odr; end
          default: begin
            cr = (kk == 1) ? 1 : -1;
            ci = -1;
            tr = rnd181(odr * cr - odi * ci);
            ti = rnd181(odr * ci + odi * cr);
          end
        endcase
        e.r[kk]   = i2sm(er + tr);
        e.i[kk]   = i2sm(ei + ti);
        e.r[kk+4] = i2sm(er - tr);
        e.i[kk+4] = i2sm(ei - ti);
      end
    end else if (sel == 2'b10) begin
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++)
          acc += ($countones(k & n) % 2 == 1) ? -x[n] : x[n];
        e.r[k] = i2sm(acc);
      end
    end else begin
      for (int k = 0; k < 8; k++) e.r[k] = i2sm(x[k]);
    end
    return e;
  endfunction

  task automatic step(input logic rst, input logic [1:0] sel, input logic [7:0][11:0] xv);
    exp_t e;
    reset    = rst;
    t_select = sel;
    xin      = xv;
    exp_q.push_back(model(rst, sel, xv));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rO%0d sel=%0d rst=%0d", k, sel, rst), obs_r[k], e.r[k]);
      check($sformatf("iO%0d sel=%0d rst=%0d", k, sel, rst), obs_i[k], e.i[k]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    logic [7:0][11:0] xr;
    xs[0] = 12'h803; xs[1] = 12'h807; xs[2] = 12'h00F; xs[3] = 12'h002;
    xs[4] = 12'h008; xs[5] = 12'h804; xs[6] = 12'h80B; xs[7] = 12'h001;
    for (int k = 0; k < 8; k++) xsat[k] = 12'h7FF;

    @(negedge clk);
    step(1'b1, 2'b01, xs);
    step(1'b0, 2'b01, xs);
    check("dft rO0", obs_r[0], 12'h001); check("dft iO0", obs_i[0], 12'h000);
    check("dft rO4", obs_r[4], 12'h011); check("dft iO4", obs_i[4], 12'h000);
    check("dft rO2", obs_r[2], 12'h001); check("dft iO2", obs_i[2], 12'h00E);
    check("dft rO6", obs_r[6], 12'h001); check("dft iO6", obs_i[6], 12'h80E);
    step(1'b0, 2'b10, xs);
    check("wht rO0", obs_r[0], 12'h001);
    check("wht rO1", obs_r[1], 12'h011);
    check("wht rO4", obs_r[4], 12'h00D);
    step(1'b0, 2'b00, xs);
    check("byp rO5", obs_r[5], 12'h804);
    step(1'b0, 2'b01, xs);
    step(1'b0, 2'b01, xsat);
    check("sat rO0", obs_r[0], 12'h7FF);
    xr = xs;
    xr[0] = 12'h800;
    step(1'b0, 2'b00, xr);
    check("neg zero rO0", obs_r[0], 12'h000);
    step(1'b0, 2'b11, xs);
    step(1'b0, 2'b01, xs);
    step(1'b1, 2'b01, xs);
    step(1'b0, 2'b01, xs);
    check("post reset rO4", obs_r[4], 12'h011);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 8; k++) begin
        xr[k] = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 7) == 0) xr[k] = {xr[k][11], 11'h7FF};
        if ($urandom_range(0, 9) == 0) xr[k] = {xr[k][11], 11'h000};
      end
      step(($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)), xr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
